// File: rtl/iq_pkg.sv
// Shared definitions for the instruction issue front end.
// Opcodes, default field widths and the end-of-program sentinel.
package iq_pkg;

  localparam int OPW_D  = 3;
  localparam int REGW_D = 3;
  localparam int IMMW_D = 4;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] LD  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // All-ones marker in the low iw bits
  function automatic logic [63:0] sentinel(int iw);
    return {64{1'b1}} >> (64 - iw);
  endfunction

endpackage

// File: rtl/iq_fetch_fifo.sv
// Small synchronous FIFO between program fetch and issue.
// Head is read combinationally; clear wins over push/pop.
module iq_fetch_fifo #(
  parameter  int W  = 8,
  parameter  int D  = 4,
  localparam int AW = $clog2(D),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_buf [D];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_cnt != '0) && !i_clear;
  assign w_push = i_push && !i_clear &&
                  ((r_cnt != CW'(D)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_buf[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_rdata = r_buf[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/instruction_issue_queue.sv
// Program memory, in-order fetch buffer and issue register
// feeding reservation-station dispatch.
module instruction_issue_queue
  import iq_pkg::*;
#(
  parameter  int    DEPTH     = 16,
  parameter  int    FETCH_BUF = 4,
  parameter  int    OPW       = OPW_D,
  parameter  int    REGW      = REGW_D,
  parameter  int    IMMW      = IMMW_D,
  parameter  string INIT_FILE = "",
  localparam int    PCW       = $clog2(DEPTH),
  localparam int    IW        = IMMW + OPW + 3 * REGW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PCW-1:0]  redirect_pc,
  input  logic            prog_we,
  input  logic [PCW-1:0]  prog_addr,
  input  logic [IW-1:0]   prog_data,
  output logic            issue_valid,
  output logic [OPW-1:0]  opcode,
  output logic [REGW-1:0] RX,
  output logic [REGW-1:0] RY,
  output logic [REGW-1:0] RZ,
  output logic [IMMW-1:0] immediate,
  output logic [PCW-1:0]  issue_pc,
  output logic            done
);

  localparam int EW = IW + PCW;
  localparam int CW = $clog2(FETCH_BUF) + 1;
  localparam logic [IW-1:0] SENT = IW'(sentinel(IW));
  localparam bit BLANK = (INIT_FILE == "");

  logic [IW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_written;
  logic [PCW-1:0]   r_pc;
  logic             r_fetch_done;
  logic             r_issue_valid;
  logic [IW-1:0]    r_ins;
  logic [PCW-1:0]   r_issue_pc;

  logic [IW-1:0]    w_word;
  logic             w_is_sent;
  logic             w_last;
  logic [CW-1:0]    w_count;
  logic [EW-1:0]    w_head;
  logic             w_accept;
  logic             w_fetch;
  logic             w_push;

  // Never-written words read as the sentinel when no image is given
  always_ff @(posedge clock) begin
    if (prog_we) begin
      r_mem[prog_addr]     <= prog_data;
      r_written[prog_addr] <= 1'b1;
    end
  end

  assign w_word    = (BLANK && !r_written[r_pc]) ? SENT
                                                 : r_mem[r_pc];
  assign w_is_sent = (w_word == SENT);
  assign w_last    = (r_pc == PCW'(DEPTH - 1));

  assign w_accept = !redirect && (w_count != '0) &&
                    (!r_issue_valid || !stall);
  assign w_fetch  = !redirect && !r_fetch_done &&
                    ((w_count != CW'(FETCH_BUF)) || w_accept);
  assign w_push   = w_fetch && !w_is_sent;

  iq_fetch_fifo #(
    .W (EW),
    .D (FETCH_BUF)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_wdata ({w_word, r_pc}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc         <= '0;
      r_fetch_done <= 1'b0;
    end else if (redirect) begin
      r_pc         <= redirect_pc;
      r_fetch_done <= 1'b0;
    end else if (w_fetch) begin
      if (w_is_sent || w_last) r_fetch_done <= 1'b1;
      else                     r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issue_valid <= 1'b0;
      r_ins         <= '0;
      r_issue_pc    <= '0;
    end else if (redirect) begin
      r_issue_valid <= 1'b0;
    end else if (w_accept) begin
      r_issue_valid <= 1'b1;
      {r_ins, r_issue_pc} <= w_head;
    end else if (r_issue_valid && !stall) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign issue_valid = r_issue_valid;
  assign immediate   = r_ins[IW-1 -: IMMW];
  assign opcode      = r_ins[3*REGW+OPW-1 -: OPW];
  assign RX          = r_ins[3*REGW-1 -: REGW];
  assign RY          = r_ins[2*REGW-1 -: REGW];
  assign RZ          = r_ins[REGW-1:0];
  assign issue_pc    = r_issue_pc;
  assign done        = r_fetch_done && (w_count == '0) &&
                       !r_issue_valid;

endmodule

// File: tb/tb_instruction_issue_queue.sv
// Directed bench for instruction_issue_queue.
// Expected values are hand-derived from the program images.
module tb_instruction_issue_queue;
  import iq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        issue_valid;
  logic [2:0]  opcode;
  logic [2:0]  RX, RY, RZ;
  logic [3:0]  immediate;
  logic [3:0]  issue_pc;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] prog [16];

  instruction_issue_queue dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .issue_valid (issue_valid),
    .opcode      (opcode),
    .RX          (RX),
    .RY          (RY),
    .RZ          (RZ),
    .immediate   (immediate),
    .issue_pc    (issue_pc),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] ins();
    return {immediate, opcode, RX, RY, RZ};
  endfunction

  // Hold reset, write the whole image, release after an edge
  task automatic restart();
    reset = 1'b1;
    redirect = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic expect_issue(string tag, logic [15:0] w,
                              logic [3:0] pc);
    chk({tag, ".v"},   32'(issue_valid), 32'd1);
    chk({tag, ".ins"}, 32'(ins()), 32'(w));
    chk({tag, ".pc"},  32'(issue_pc), 32'(pc));
  endtask

  initial begin
    #1;
    chk("rst.valid", 32'(issue_valid), 32'd0);
    chk("rst.done",  32'(done), 32'd0);
    chk("rst.pc",    32'(issue_pc), 32'd0);

    // Basic ADD, SUB, sentinel
    for (int i = 0; i < 16; i++) prog[i] = 16'hFFFF;
    prog[0] = 16'h000A;
    prog[1] = 16'h0241;
    restart();
    tick();
    chk("t1.e1.valid", 32'(issue_valid), 32'd0);
    tick();
    expect_issue("t1.e2", 16'h000A, 4'd0);
    chk("t1.e2.op", 32'(opcode), 32'(ADD));
    chk("t1.e2.RX", 32'(RX), 32'd0);
    chk("t1.e2.RY", 32'(RY), 32'd1);
    chk("t1.e2.RZ", 32'(RZ), 32'd2);
    tick();
    expect_issue("t1.e3", 16'h0241, 4'd1);
    chk("t1.e3.op", 32'(opcode), 32'(SUB));
    chk("t1.e3.done", 32'(done), 32'd0);
    tick();
    chk("t1.e4.valid", 32'(issue_valid), 32'd0);
    chk("t1.e4.done",  32'(done), 32'd1);

    // Stall after the first issue
    restart();
    tick();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_issue("t2.stall", 16'h000A, 4'd0);
      chk("t2.stall.done", 32'(done), 32'd0);
    end
    chk("t2.count", 32'(dut.w_count), 32'd1);
    chk("t2.fdone", 32'(dut.r_fetch_done), 32'd1);
    stall = 1'b0;
    tick();
    expect_issue("t2.rel", 16'h0241, 4'd1);
    tick();
    chk("t2.end.valid", 32'(issue_valid), 32'd0);
    chk("t2.end.done",  32'(done), 32'd1);

    // Buffer saturation then back-to-back issue
    for (int i = 0; i < 16; i++)
      prog[i] = (i < 8) ? (16'h2000 | 16'(i)) : 16'hFFFF;
    stall = 1'b1;
    restart();
    for (int k = 0; k < 8; k++) tick();
    chk("t3.count", 32'(dut.w_count), 32'd4);
    chk("t3.pc",    32'(dut.r_pc), 32'd5);
    expect_issue("t3.held", 16'h2000, 4'd0);
    stall = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      expect_issue("t3.run", 16'h2000 | 16'(k), 4'(k));
    end
    tick();
    chk("t3.end.valid", 32'(issue_valid), 32'd0);
    chk("t3.end.done",  32'(done), 32'd1);

    // Redirect to an LD while stalled, then onto a sentinel
    prog[6] = 16'h1457;
    stall = 1'b1;
    restart();
    tick();
    tick();
    tick();
    chk("t4.pre.valid", 32'(issue_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 4'd6;
    tick();
    redirect = 1'b0;
    chk("t4.r1.valid", 32'(issue_valid), 32'd0);
    tick();
    chk("t4.r2.valid", 32'(issue_valid), 32'd0);
    tick();
    expect_issue("t4.ld", 16'h1457, 4'd6);
    chk("t4.ld.op",  32'(opcode), 32'(LD));
    chk("t4.ld.RX",  32'(RX), 32'd1);
    chk("t4.ld.RY",  32'(RY), 32'd2);
    chk("t4.ld.RZ",  32'(RZ), 32'd7);
    chk("t4.ld.imm", 32'(immediate), 32'd1);
    redirect = 1'b1;
    redirect_pc = 4'd8;
    tick();
    redirect = 1'b0;
    chk("t4.s1.valid", 32'(issue_valid), 32'd0);
    chk("t4.s1.done",  32'(done), 32'd0);
    tick();
    chk("t4.s2.done",  32'(done), 32'd1);
    stall = 1'b0;

    // Full memory, no wrap back to pc 0
    for (int i = 0; i < 16; i++) prog[i] = 16'h3000 | 16'(i);
    restart();
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      expect_issue("t5.run", 16'h3000 | 16'(k), 4'(k));
      chk("t5.run.done", 32'(done), 32'd0);
    end
    tick();
    chk("t5.end.valid", 32'(issue_valid), 32'd0);
    chk("t5.end.done",  32'(done), 32'd1);
    tick();
    chk("t5.hold.valid", 32'(issue_valid), 32'd0);
    chk("t5.hold.done",  32'(done), 32'd1);

    // Asynchronous reset mid-stream; memory survives
    restart();
    for (int k = 0; k < 5; k++) tick();
    expect_issue("t6.pre", 16'h3003, 4'd3);
    #3;
    reset = 1'b1;
    #1;
    chk("t6.rst.valid", 32'(issue_valid), 32'd0);
    chk("t6.rst.ins",   32'(ins()), 32'd0);
    chk("t6.rst.pc",    32'(issue_pc), 32'd0);
    chk("t6.rst.done",  32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6.e1.valid", 32'(issue_valid), 32'd0);
    tick();
    expect_issue("t6.e2", 16'h3000, 4'd0);
    tick();
    expect_issue("t6.e3", 16'h3001, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
